// File: rtl/spi_req_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared SPI byte master.
// Per-requester fields are packed: slice i belongs to requester i.
// The slave view is the arbiter. The master view is the clients plus the SPI master.
interface spi_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
) ();
  // client side
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*8-1:0]     tx_data;
  logic [NUM_REQ-1:0]       tx_take;
  logic [7:0]               rx_data;
  logic [NUM_REQ-1:0]       rx_valid;
  logic [NUM_REQ-1:0]       done;
  logic                     err;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       cs_n;
  // SPI byte master side
  logic                     m_start;
  logic [7:0]               m_data_in;
  logic                     m_busy;
  logic [7:0]               m_data_out;

  modport slave (
    input  req, req_len, tx_data, m_busy, m_data_out,
    output tx_take, rx_data, rx_valid, done, err, grant, cs_n, m_start, m_data_in
  );

  modport master (
    output req, req_len, tx_data, m_busy, m_data_out,
    input  tx_take, rx_data, rx_valid, done, err, grant, cs_n, m_start, m_data_in
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Purpose: gives one SPI byte master to one requester at a time, round-robin, for a whole burst.
// Latency: grant 1 clk after req in IDLE. First m_start CS_SETUP+1 clks after grant. done 1 clk after last rx_valid.
// Backpressure: requesters hold req until they are granted. Bytes are paced by m_busy plus GAP_CYCLES idle clks.
module spi_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LEN_W      = 4,
  parameter int CS_SETUP   = 2,
  parameter int GAP_CYCLES = 2,
  parameter int BUSY_TO    = 15
) (
  input logic              clk_i,
  input logic              rst_i,
  spi_req_arbiter_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_M0  = (CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES;
  localparam int CNT_MAX = (CNT_M0 > BUSY_TO) ? CNT_M0 : BUSY_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  // Last value of the shared counter in each timed state.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((CS_SETUP   > 0) ? CS_SETUP - 1   : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'((BUSY_TO    > 0) ? BUSY_TO - 1    : 0);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, WAIT_BUSY, WAIT_DONE, GAP, RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tout_q, tout_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
  logic               m_start_q, m_start_d;
  logic [7:0]         m_data_in_q, m_data_in_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
  logic [NUM_REQ-1:0] tx_take_q, tx_take_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] owner_oh;

  assign pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  // Round-robin search: the first pending req after the last owner, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!pick_vld && bus.req[IDX_W'(idx)]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(idx);
      end
    end
  end

  // Burst sequencer. Every output is registered, so each state's actions appear the cycle after it.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    tout_d      = tout_q;
    grant_d     = grant_q;
    cs_n_d      = cs_n_q;
    m_data_in_d = m_data_in_q;
    rx_data_d   = rx_data_q;
    m_start_d   = 1'b0;
    rx_valid_d  = '0;
    tx_take_d   = '0;
    done_d      = '0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          rem_d   = bus.req_len[int'(pick)*LEN_W +: LEN_W];
          grant_d = pick_oh;
          cs_n_d  = ~pick_oh;
          tout_d  = 1'b0;
          cnt_d   = '0;
          state_d = (CS_SETUP == 0) ? LOAD : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = LOAD;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      LOAD: begin
        m_start_d   = 1'b1;
        m_data_in_d = bus.tx_data[int'(owner_q)*8 +: 8];
        tx_take_d   = owner_oh;
        cnt_d       = '0;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.m_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == BUSY_LAST) begin
          // The master never responded. Close the burst and flag it on done.
          tout_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.m_busy) begin
          rx_data_d  = bus.m_data_out;
          rx_valid_d = owner_oh;
          if (rem_q == '0) begin
            state_d = RELEASE;
          end else begin
            rem_d   = rem_q - LEN_W'(1);
            cnt_d   = '0;
            state_d = (GAP_CYCLES == 0) ? LOAD : GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = LOAD;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      RELEASE: begin
        cs_n_d  = '1;
        grant_d = '0;
        done_d  = owner_oh;
        err_d   = tout_q;
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset is asynchronous so a mid-burst reset drops cs_n at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      rem_q       <= '0;
      cnt_q       <= '0;
      tout_q      <= 1'b0;
      grant_q     <= '0;
      cs_n_q      <= '1;
      m_start_q   <= 1'b0;
      m_data_in_q <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= '0;
      tx_take_q   <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      tout_q      <= tout_d;
      grant_q     <= grant_d;
      cs_n_q      <= cs_n_d;
      m_start_q   <= m_start_d;
      m_data_in_q <= m_data_in_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_take_q   <= tx_take_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.m_start   = m_start_q;
  assign bus.m_data_in = m_data_in_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_take   = tx_take_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter, with a behavioural SPI byte master and per-requester byte tables.
// The slave side of the SPI master returns the sent byte plus 0x22.
// A busy byte lasts BYTE_CYC clks.
`timescale 1ns/1ps
module tb_spi_req_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int LEN_W      = 4;
  localparam int CS_SETUP   = 2;
  localparam int GAP_CYCLES = 2;
  localparam int BUSY_TO    = 15;
  localparam int BYTE_CYC   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_req_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

  spi_req_arbiter #(
    .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP),
    .GAP_CYCLES(GAP_CYCLES), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- cycle counter ----------------
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- tx byte tables ----------------
  logic [7:0] tx_tab [NUM_REQ][8];
  logic [2:0] tptr   [NUM_REQ];

  always_comb begin
    bus.tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.tx_data[i*8 +: 8] = tx_tab[i][tptr[i]];
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) tptr[i] = 3'd0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) if (bus.tx_take[i]) tptr[i] = tptr[i] + 3'd1;
    end
  end

  // ---------------- SPI byte master model ----------------
  logic slave_en = 1'b1;
  initial begin
    logic [7:0] b;
    bus.m_busy     = 1'b0;
    bus.m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_start && slave_en) begin
        b          = bus.m_data_in + 8'h22;
        bus.m_busy = 1'b1;
        for (int n = 0; n < BYTE_CYC && !rst; n++) @(negedge clk);
        bus.m_data_out = b;
        bus.m_busy     = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int mstart_n = 0, mstart_last = 0, mstart_prev = 0;
  logic [7:0] mdata_last = 8'h00;
  logic [7:0] rx_last = 8'h00;
  int take_n [NUM_REQ];
  int rxv_n  [NUM_REQ];
  int done_n [NUM_REQ];
  int rxv_cyc = 0, done_cyc = 0;
  int err_n = 0, err_bad = 0, multi = 0, csbad = 0;
  int fall_cyc = 0;
  logic [NUM_REQ-1:0] grant_prev = '0;
  int order [$];
  int gaps  [$];

  function automatic int oh2idx(input logic [NUM_REQ-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      take_n[i] = 0; rxv_n[i] = 0; done_n[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (bus.m_start) begin
        mstart_prev = mstart_last;
        mstart_last = cyc;
        mstart_n++;
        mdata_last  = bus.m_data_in;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.tx_take[i]) take_n[i]++;
        if (bus.rx_valid[i]) begin
          rxv_n[i]++;
          rx_last = bus.rx_data;
          rxv_cyc = cyc;
        end
        if (bus.done[i]) begin
          done_n[i]++;
          done_cyc = cyc;
        end
      end
      if (bus.err) err_n++;
      if (bus.err && bus.done == '0) err_bad++;
      if ($countones(bus.grant) > 1) multi++;
      if (bus.cs_n != ~bus.grant) csbad++;
      if (bus.grant != '0 && grant_prev == '0) begin
        order.push_back(oh2idx(bus.grant));
        gaps.push_back(cyc - fall_cyc);
      end
      if (bus.grant == '0 && grant_prev != '0) fall_cyc = cyc;
      grant_prev = bus.grant;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input logic [1:0] idx, input string tag);
    int n;
    n = 0;
    while (!bus.done[idx] && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.done[idx]), 32'd1);
  endtask

  task automatic wait_grant_clear(input string tag);
    int n;
    n = 0;
    while (bus.grant != '0 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.grant), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int exp_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    int g, s_take, s_rxv, s_mst, s_err, s_done, o0, n, cs_hi;
    bus.req     = '0;
    bus.req_len = '0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) tx_tab[i][k] = 8'(i*16 + k + 1);
    tx_tab[0][0] = 8'hAA;
    tx_tab[2][0] = 8'h11;
    tx_tab[2][1] = 8'h22;
    tx_tab[2][2] = 8'h33;

    // reset values
    repeat (3) tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_cs_n", 32'(bus.cs_n), 32'hF);
    chk("rst_pulses", 32'({bus.m_start, bus.rx_valid, bus.tx_take, bus.done, bus.err}), 32'h0);
    chk("rst_data", 32'({bus.m_data_in, bus.rx_data}), 32'h0);
    rst = 1'b0;
    tick();

    // single byte on requester 0
    bus.req = 4'b0001;
    bus.req_len[0 +: LEN_W] = 4'd0;
    s_take = take_n[0]; s_rxv = rxv_n[0]; s_mst = mstart_n; s_err = err_n;
    tick();
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_cs_n", 32'(bus.cs_n), 32'hE);
    g = cyc;
    bus.req = 4'b0000;
    wait_done(2'd0, "t1_done");
    chk("t1_cs_rel", 32'({bus.cs_n, bus.grant}), 32'hF0);
    chk("t1_setup_lat", 32'(mstart_last - g), 32'd3);
    chk("t1_mdata", 32'(mdata_last), 32'hAA);
    chk("t1_rxdata", 32'(rx_last), 32'hCC);
    chk("t1_rx_lat", 32'(rxv_cyc - mstart_last), 32'd9);
    chk("t1_done_lat", 32'(done_cyc - rxv_cyc), 32'd1);
    chk("t1_counts", 32'({8'(take_n[0]-s_take), 8'(rxv_n[0]-s_rxv), 8'(mstart_n-s_mst), 8'(err_n-s_err)}),
        32'h01010100);

    // 3-byte burst on requester 2
    bus.req = 4'b0100;
    bus.req_len[2*LEN_W +: LEN_W] = 4'd2;
    s_take = take_n[2]; s_rxv = rxv_n[2]; s_mst = mstart_n;
    tick();
    chk("t2_grant", 32'(bus.grant), 32'h4);
    bus.req = 4'b0000;
    n = 0; cs_hi = 0;
    while (!bus.done[2] && n < 400) begin
      tick();
      n++;
      if (bus.cs_n[2] && !bus.done[2]) cs_hi++;
    end
    chk("t2_done", 32'(bus.done[2]), 32'd1);
    chk("t2_cs_low", 32'(cs_hi), 32'd0);
    chk("t2_takes", 32'(take_n[2] - s_take), 32'd3);
    chk("t2_rxv", 32'(rxv_n[2] - s_rxv), 32'd3);
    chk("t2_mstarts", 32'(mstart_n - s_mst), 32'd3);
    chk("t2_spacing", 32'(mstart_last - mstart_prev), 32'd12);
    chk("t2_last_bytes", 32'({mdata_last, rx_last}), 32'h3355);

    // reset so the round-robin pointer starts from requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // round robin with every requester pending
    bus.req_len = '0;
    o0 = order.size();
    bus.req = 4'b1111;
    n = 0;
    while (order.size() < o0 + 5 && n < 600) begin
      tick();
      n++;
    end
    bus.req = 4'b0000;
    chk("t3_grants", 32'(order.size() - o0), 32'd5);
    wait_grant_clear("t3_idle");
    for (int i = 0; i < 5; i++)
      if (o0 + i < order.size()) chk($sformatf("t3_order%0d", i), 32'(order[o0+i]), 32'(exp_rr[i]));
    for (int i = 1; i < 5; i++)
      if (o0 + i < gaps.size()) chk($sformatf("t3_gap%0d", i), 32'(gaps[o0+i]), 32'd1);

    // request and length changes mid-burst are ignored
    bus.req = 4'b0010;
    bus.req_len[1*LEN_W +: LEN_W] = 4'd1;
    s_take = take_n[1]; s_rxv = rxv_n[1];
    tick();
    chk("t4_grant1", 32'(bus.grant), 32'h2);
    repeat (5) tick();
    bus.req = 4'b1000;
    bus.req_len[1*LEN_W +: LEN_W] = 4'hF;
    wait_done(2'd1, "t4_done1");
    chk("t4_rxv", 32'(rxv_n[1] - s_rxv), 32'd2);
    chk("t4_takes", 32'(take_n[1] - s_take), 32'd2);
    tick();
    chk("t4_grant3", 32'(bus.grant), 32'h8);
    bus.req = 4'b0000;
    wait_done(2'd3, "t4_done3");

    // busy timeout
    slave_en = 1'b0;
    s_rxv = rxv_n[0]; s_mst = mstart_n;
    bus.req = 4'b0001;
    tick();
    chk("t5_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    wait_done(2'd0, "t5_done");
    chk("t5_err", 32'(bus.err), 32'd1);
    chk("t5_cs_rel", 32'(bus.cs_n), 32'hF);
    chk("t5_to_lat", 32'(done_cyc - mstart_last), 32'd16);
    chk("t5_counts", 32'({8'(rxv_n[0]-s_rxv), 8'(mstart_n-s_mst)}), 32'h0001);
    tick();
    chk("t5_err_pulse", 32'(bus.err), 32'd0);
    slave_en = 1'b1;

    // asynchronous reset in the middle of a byte
    bus.req = 4'b0010;
    tick();
    chk("t6_grant", 32'(bus.grant), 32'h2);
    bus.req = 4'b0000;
    n = 0;
    while (!bus.m_busy && n < 50) begin
      tick();
      n++;
    end
    chk("t6_busy", 32'(bus.m_busy), 32'd1);
    repeat (2) tick();
    s_done = done_n[0] + done_n[1] + done_n[2] + done_n[3];
    rst = 1'b1;
    #1;
    chk("t6_async_cs", 32'(bus.cs_n), 32'hF);
    chk("t6_async_grant", 32'(bus.grant), 32'h0);
    chk("t6_async_mstart", 32'(bus.m_start), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_no_done", 32'(done_n[0] + done_n[1] + done_n[2] + done_n[3] - s_done), 32'd0);

    // first grant after reset goes to requester 0 even with requester 1 pending
    bus.req = 4'b0011;
    tick();
    chk("t7_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    wait_done(2'd0, "t7_done");

    // whole-run invariants
    chk("inv_one_hot", 32'(multi), 32'd0);
    chk("inv_cs_vs_grant", 32'(csbad), 32'd0);
    chk("inv_err_with_done", 32'(err_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
